// File: rtl/turbo_rx_deframer.sv
// Receive-side deframer for the turbo encoder output stream: splits each block into
// systematic and tail bits, re-checks parity-1 against a local RSC encoder, counts bad blocks.
module turbo_rx_deframer #(
    parameter int LEN_SHORT = 4,
    parameter int LEN_LONG  = 6,
    parameter int TAIL_LEN  = 4,
    parameter int CNT_W     = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        look_now,
    input  logic        xk,
    input  logic        zk,
    input  logic        zkp,
    input  logic        length_in,
    output logic        ck_out,
    output logic        zkp_out,
    output logic        ck_valid,
    output logic        block_start,
    output logic        block_end,
    output logic [11:0] tail_bits,
    output logic        tail_valid,
    output logic        blk_err,
    output logic        frame_err,
    output logic [15:0] err_count,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam int SW = 3 * (TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] K_SHORT  = CNT_W'(LEN_SHORT);
    localparam logic [CNT_W-1:0] K_LONG   = CNT_W'(LEN_LONG);
    localparam logic [CNT_W-1:0] TAIL_MAX = CNT_W'(TAIL_LEN - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, k_reg, k_next;
    logic             d1_reg, d2_reg, d3_reg, d1_next, d2_next, d3_next;
    logic             err_flag_reg, err_flag_next;
    logic [SW-1:0]    shift_reg, shift_next, shift_shifted;
    logic [11:0]      tail_bits_reg, tail_bits_next;
    logic [15:0]      err_count_reg, err_count_next;
    logic             ck_out_reg, ck_out_next, zkp_out_reg, zkp_out_next;
    logic             ck_valid_reg, ck_valid_next, block_start_reg, block_start_next;
    logic             block_end_reg, block_end_next, tail_valid_reg, tail_valid_next;
    logic             blk_err_reg, blk_err_next, frame_err_reg, frame_err_next;
    logic             busy_reg, busy_next;

    // Working values for the current data bit; IDLE means bit 0 of a fresh block.
    logic             first, s1, s2, s3, err_cur, fb, z_exp, inc;
    logic [CNT_W-1:0] k_cur, cnt_cur;

    generate
        for (genvar gi = 0; gi < TAIL_LEN - 1; gi++) begin : g_tail_shift
            if (gi == 0) begin : g_head
                assign shift_shifted[2:0] = {xk, zk, zkp};
            end else begin : g_body
                assign shift_shifted[3*gi +: 3] = shift_reg[3*(gi-1) +: 3];
            end
        end
    endgenerate

    assign first   = (state_reg == IDLE);
    assign k_cur   = first ? (length_in ? K_LONG : K_SHORT) : k_reg;
    assign cnt_cur = first ? '0 : cnt_reg;
    assign s1      = first ? 1'b0 : d1_reg;
    assign s2      = first ? 1'b0 : d2_reg;
    assign s3      = first ? 1'b0 : d3_reg;
    assign err_cur = first ? 1'b0 : err_flag_reg;
    assign fb      = xk ^ s2 ^ s3;
    assign z_exp   = fb ^ s1 ^ s3;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        k_next           = k_reg;
        d1_next          = d1_reg;
        d2_next          = d2_reg;
        d3_next          = d3_reg;
        err_flag_next    = err_flag_reg;
        shift_next       = shift_reg;
        tail_bits_next   = tail_bits_reg;
        ck_out_next      = 1'b0;
        zkp_out_next     = 1'b0;
        ck_valid_next    = 1'b0;
        block_start_next = 1'b0;
        block_end_next   = 1'b0;
        tail_valid_next  = 1'b0;
        blk_err_next     = 1'b0;
        frame_err_next   = 1'b0;
        inc              = 1'b0;

        if (state_reg != IDLE && !look_now) begin
            // Truncated block: report once and resynchronise on the next look_now.
            frame_err_next = 1'b1;
            inc            = 1'b1;
            state_next     = IDLE;
            cnt_next       = '0;
        end else if (look_now && state_reg != TAIL) begin
            ck_out_next      = xk;
            zkp_out_next     = zkp;
            ck_valid_next    = 1'b1;
            block_start_next = first;
            k_next           = k_cur;
            d1_next          = fb;
            d2_next          = s1;
            d3_next          = s2;
            err_flag_next    = err_cur | (zk != z_exp);
            if (cnt_cur == k_cur - CNT_W'(1)) begin
                state_next = TAIL;
                cnt_next   = '0;
            end else begin
                state_next = DATA;
                cnt_next   = cnt_cur + CNT_W'(1);
            end
        end else if (look_now) begin
            shift_next = shift_shifted;
            if (cnt_reg == TAIL_MAX) begin
                tail_bits_next  = {shift_reg, xk, zk, zkp};
                tail_valid_next = 1'b1;
                block_end_next  = 1'b1;
                blk_err_next    = err_flag_reg;
                inc             = err_flag_reg;
                state_next      = IDLE;
                cnt_next        = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        err_count_next = (inc && err_count_reg != 16'hFFFF) ? err_count_reg + 16'd1 : err_count_reg;
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            k_reg           <= '0;
            d1_reg          <= 1'b0;
            d2_reg          <= 1'b0;
            d3_reg          <= 1'b0;
            err_flag_reg    <= 1'b0;
            shift_reg       <= '0;
            tail_bits_reg   <= '0;
            err_count_reg   <= '0;
            ck_out_reg      <= 1'b0;
            zkp_out_reg     <= 1'b0;
            ck_valid_reg    <= 1'b0;
            block_start_reg <= 1'b0;
            block_end_reg   <= 1'b0;
            tail_valid_reg  <= 1'b0;
            blk_err_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            k_reg           <= k_next;
            d1_reg          <= d1_next;
            d2_reg          <= d2_next;
            d3_reg          <= d3_next;
            err_flag_reg    <= err_flag_next;
            shift_reg       <= shift_next;
            tail_bits_reg   <= tail_bits_next;
            err_count_reg   <= err_count_next;
            ck_out_reg      <= ck_out_next;
            zkp_out_reg     <= zkp_out_next;
            ck_valid_reg    <= ck_valid_next;
            block_start_reg <= block_start_next;
            block_end_reg   <= block_end_next;
            tail_valid_reg  <= tail_valid_next;
            blk_err_reg     <= blk_err_next;
            frame_err_reg   <= frame_err_next;
            busy_reg        <= busy_next;
        end
    end

    assign ck_out      = ck_out_reg;
    assign zkp_out     = zkp_out_reg;
    assign ck_valid    = ck_valid_reg;
    assign block_start = block_start_reg;
    assign block_end   = block_end_reg;
    assign tail_bits   = tail_bits_reg;
    assign tail_valid  = tail_valid_reg;
    assign blk_err     = blk_err_reg;
    assign frame_err   = frame_err_reg;
    assign err_count   = err_count_reg;
    assign busy        = busy_reg;
endmodule

// File: doc/turbo_rx_deframer.md
Name: turbo_rx_deframer

Overview:
- Receive-side companion to the turbo encoder output stage.
- Consumes the serial {xk, zk, zkp} stream qualified by look_now, plus the block-size flag from the length FIFO, and splits each block into systematic data bits and trellis-tail bits.
- Re-runs the constituent RSC encoder on the recovered systematic bits and checks every received zk against it, flagging per-block parity errors and malformed (truncated) blocks.
- Sits at the encoder output boundary as a loopback checker and front end for downstream decode.

Parameters:
- LEN_SHORT, 4, data length K when length_in=0 (production value 40).
- LEN_LONG, 6, data length K when length_in=1 (production value 6144).
- TAIL_LEN, 4, trellis-termination cycles per block.
- CNT_W, 14, width of the bit counter; must hold LEN_LONG-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- look_now  in  1  stream valid; high for every data and tail cycle of a block
- xk  in  1  systematic bit (data phase) / tail bit 0
- zk  in  1  parity-1 bit (data phase) / tail bit 1
- zkp  in  1  parity-2 bit (data phase) / tail bit 2
- length_in  in  1  block-size flag, sampled on the first data cycle
- ck_out  out  1  recovered systematic bit
- zkp_out  out  1  parity-2 bit, passed through for downstream use
- ck_valid  out  1  ck_out/zkp_out valid
- block_start  out  1  one-cycle pulse with the first ck_valid of a block
- block_end  out  1  one-cycle pulse with tail_valid
- tail_bits  out  12  captured tail, {xk,zk,zkp} per tail cycle, first cycle in [11:9]
- tail_valid  out  1  one-cycle pulse; tail_bits stable until the next tail_valid
- blk_err  out  1  valid with block_end; 1 if any zk mismatch occurred in the block
- frame_err  out  1  one-cycle pulse when look_now drops mid-block
- err_count  out  16  saturating count of blocks with blk_err or frame_err
- busy  out  1  high in DATA or TAIL

Behaviour:
- Reset: every output is 0; state=IDLE; counter=0; RSC state=000; tail_bits=0. A reset asserted mid-block discards that block with no block_end and no frame_err.
- All outputs are registered; latency is 1 cycle from an input sample to the corresponding ck_valid, tail_valid or frame_err.
- States: IDLE, DATA, TAIL.
- IDLE, look_now=1:
  - This cycle is data bit 0.
  - Latch K from length_in: LEN_LONG if 1, else LEN_SHORT.
  - Clear RSC state and error flag, then process bit 0.
  - Go to DATA with cnt=1, or go straight to TAIL if K=1.
- DATA, look_now=1:
  - Emit ck_out=xk and zkp_out=zkp with ck_valid.
  - RSC check: a = xk^d2^d3; expected z = a^d1^d3; if zk != z, set the block error flag.
  - Update the RSC state: d1<=a, d2<=d1, d3<=d2.
  - When cnt=K-1, go to TAIL with cnt=0; otherwise cnt+1.
- TAIL, look_now=1: shift {xk,zk,zkp} into the tail shift register; no ck_valid. On cnt=TAIL_LEN-1:
  - Pulse tail_valid and block_end.
  - Drive blk_err from the error flag.
  - Increment err_count if blk_err.
  - Return to IDLE.
- Back-to-back blocks: look_now high the cycle right after the last tail cycle is accepted as bit 0 of the next block, with no bubble.
- look_now=0 in DATA or TAIL:
  - Pulse frame_err and increment err_count.
  - Suppress block_end and tail_valid, and go to IDLE.
  - Partial data already emitted is not retracted.
- err_count saturates at 16'hFFFF. It increments at most once per block.
- length_in is ignored outside the first data cycle.
- Tail bits are not parity-checked.

Test Plan:
- Single short block, length_in=0. Data phase: xk=1,0,1,1 with zk=1,1,0,1 and zkp=0,1,1,0. Tail phase: 4 cycles of {1,0,1}.
  -> ck_out=1,0,1,1 with ck_valid for 4 cycles and block_start on the first.
  -> tail_bits=12'b101101101101 with block_end, tail_valid and blk_err=0.
  -> err_count=0.
- Same block with the third zk flipped (1,1,1,1). -> blk_err=1 at block_end; err_count=1.
- Long block, length_in=1: six data cycles followed immediately by a second short block with no gap.
  -> 6 ck_valid, then tail, then block_start on the very next ck_valid.
  -> The second block uses K=4.
- look_now dropped after 2 data cycles. -> frame_err pulse 1 cycle later, no block_end, state IDLE, err_count increments by 1. The next block decodes cleanly.
- rst asserted during TAIL cycle 2. -> all outputs 0 the following cycle, no block_end, err_count=0. A new block after reset decodes normally.
- Preload err_count near saturation via 65535 erroneous blocks, then send 2 more. -> err_count holds 16'hFFFF.
